// File: rtl/snn_pkg.sv
// Shared definitions for the spiking layer.
//   snn_state_t : layer control states
//   SAT_GUARD   : extra headroom bits used when forming the membrane update
//                 before it is clamped back to the membrane width
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } snn_state_t;

    localparam int unsigned SAT_GUARD = 2;

endpackage

// File: rtl/snn_lif.sv
// One leaky integrate-and-fire neuron with binary (+1/-1) synapses.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear_i      : zero membrane and spike count (new inference)
//   accept_i     : a timestep is being consumed this cycle
//   spike_in_i   : input spikes of the current timestep
//   w_i          : synapse signs, 1 = +1, 0 = -1
//   thr_i        : signed firing threshold
//   fire_o       : neuron fires if this timestep is accepted (combinational)
//   cnt_o        : saturating spike total
module snn_lif
    import snn_pkg::*;
#(
    parameter int unsigned N_IN       = 4,
    parameter int unsigned VMEM_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 5,
    parameter int unsigned LEAK_SHIFT = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic                         accept_i,
    input  logic [N_IN-1:0]              spike_in_i,
    input  logic [N_IN-1:0]              w_i,
    input  logic signed [VMEM_WIDTH-1:0] thr_i,
    output logic                         fire_o,
    output logic [CNT_WIDTH-1:0]         cnt_o
);

    localparam int unsigned EW = VMEM_WIDTH + SAT_GUARD;
    localparam logic signed [EW-1:0] ONE  = {{(EW-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] VMAX = {{(SAT_GUARD+1){1'b0}}, {(VMEM_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] VMIN = {{(SAT_GUARD+1){1'b1}}, {(VMEM_WIDTH-1){1'b0}}};

    logic signed [VMEM_WIDTH-1:0] v_q, v_next;
    logic [CNT_WIDTH-1:0]         cnt_q;
    logic signed [EW-1:0]         v_ext, syn, sum;

    always_comb begin
        syn = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (spike_in_i[i]) begin
                syn = w_i[i] ? (syn + ONE) : (syn - ONE);
            end
        end
        v_ext = {{SAT_GUARD{v_q[VMEM_WIDTH-1]}}, v_q};
        sum   = v_ext - (v_ext >>> LEAK_SHIFT) + syn;
        if (sum > VMAX) begin
            v_next = VMAX[VMEM_WIDTH-1:0];
        end else if (sum < VMIN) begin
            v_next = VMIN[VMEM_WIDTH-1:0];
        end else begin
            v_next = sum[VMEM_WIDTH-1:0];
        end
        fire_o = (v_next >= thr_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            v_q   <= '0;
            cnt_q <= '0;
        end else if (accept_i) begin
            v_q <= fire_o ? '0 : v_next;
            if (fire_o && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/snn_layer.sv
// Fully connected layer of N_OUT LIF neurons driven by N_IN spike channels
// over T_STEPS timesteps per inference.
// Ports:
//   CLK, nRST          : clock, asynchronous active-low reset
//   start              : begin an inference (honoured only when idle)
//   spike_in, in_valid : one timestep of input spikes; in_ready = accepted
//   weights            : binary synapses, bit [o*N_IN+i]
//   threshold          : signed firing threshold, latched at start
//   spike_out/out_valid: registered per-timestep output spikes
//   spike_count        : per-neuron saturating spike totals
//   busy, finish       : running flag, end-of-inference pulse
module snn_layer
    import snn_pkg::*;
#(
    parameter int unsigned N_IN       = 4,
    parameter int unsigned N_OUT      = 4,
    parameter int unsigned T_STEPS    = 16,
    parameter int unsigned VMEM_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 5,
    parameter int unsigned LEAK_SHIFT = 2
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       start,
    input  logic [N_IN-1:0]            spike_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_OUT*N_IN-1:0]      weights,
    input  logic [VMEM_WIDTH-1:0]      threshold,
    output logic [N_OUT-1:0]           spike_out,
    output logic                       out_valid,
    output logic [N_OUT*CNT_WIDTH-1:0] spike_count,
    output logic                       busy,
    output logic                       finish
);

    localparam int unsigned TW = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;

    snn_state_t                   state_q;
    logic [TW-1:0]                tstep_q;
    logic signed [VMEM_WIDTH-1:0] thr_q;
    logic [N_OUT-1:0]             spike_out_q;
    logic                         out_valid_q;
    logic                         finish_q;
    logic [N_OUT-1:0]             fire;
    logic                         accept;
    logic                         clear;
    logic                         last_step;

    assign accept    = in_valid && (state_q == RUN);
    assign clear     = start && (state_q == IDLE);
    assign last_step = (tstep_q == TW'(T_STEPS - 1));

    genvar o;
    generate
        for (o = 0; o < N_OUT; o++) begin : g_neuron
            snn_lif #(
                .N_IN      (N_IN),
                .VMEM_WIDTH(VMEM_WIDTH),
                .CNT_WIDTH (CNT_WIDTH),
                .LEAK_SHIFT(LEAK_SHIFT)
            ) u_lif (
                .clk       (CLK),
                .rst_n     (nRST),
                .clear_i   (clear),
                .accept_i  (accept),
                .spike_in_i(spike_in),
                .w_i       (weights[o*N_IN +: N_IN]),
                .thr_i     (thr_q),
                .fire_o    (fire[o]),
                .cnt_o     (spike_count[o*CNT_WIDTH +: CNT_WIDTH])
            );
        end
    endgenerate

    // finish is raised on the edge that accepts the last step, so it is
    // high during DONE together with the final out_valid.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            tstep_q     <= '0;
            thr_q       <= '0;
            spike_out_q <= '0;
            out_valid_q <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            out_valid_q <= accept;
            finish_q    <= 1'b0;
            if (accept) begin
                spike_out_q <= fire;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        tstep_q <= '0;
                        thr_q   <= threshold;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        if (last_step) begin
                            state_q  <= DONE;
                            finish_q <= 1'b1;
                            tstep_q  <= '0;
                        end else begin
                            tstep_q <= tstep_q + 1'b1;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign spike_out = spike_out_q;
    assign out_valid = out_valid_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_snn_layer.sv
module tb_snn_layer;

    localparam int NI = 4;
    localparam int NO = 4;
    localparam int TS = 16;

    logic             CLK = 1'b0;
    logic             nRST = 1'b1;
    logic             start = 1'b0;
    logic [NI-1:0]    spike_in = '0;
    logic             in_valid = 1'b0;
    logic [NO*NI-1:0] weights = '0;
    logic [7:0]       threshold = '0;

    logic             in_ready, out_valid, busy, finish;
    logic [NO-1:0]    spike_out;
    logic [NO*5-1:0]  spike_count;
    logic             in_ready3, out_valid3, busy3, finish3;
    logic [NO-1:0]    spike_out3;
    logic [NO*3-1:0]  spike_count3;

    snn_layer dut (
        .CLK(CLK), .nRST(nRST), .start(start), .spike_in(spike_in),
        .in_valid(in_valid), .in_ready(in_ready), .weights(weights),
        .threshold(threshold), .spike_out(spike_out), .out_valid(out_valid),
        .spike_count(spike_count), .busy(busy), .finish(finish)
    );

    snn_layer #(.CNT_WIDTH(3)) dut3 (
        .CLK(CLK), .nRST(nRST), .start(start), .spike_in(spike_in),
        .in_valid(in_valid), .in_ready(in_ready3), .weights(weights),
        .threshold(threshold), .spike_out(spike_out3), .out_valid(out_valid3),
        .spike_count(spike_count3), .busy(busy3), .finish(finish3)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 running, 2 finishing cycle.
    int          m_phase = 0;
    int          m_steps = 0;
    int          m_thr = 0;
    int          m_v[NO];
    int          m_cnt[NO];
    logic [NO-1:0] m_spk = '0;
    bit          m_ov = 0;
    bit          m_fin = 0;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_phase = 0; m_steps = 0; m_thr = 0; m_spk = '0; m_ov = 0; m_fin = 0;
            for (int o = 0; o < NO; o++) begin m_v[o] = 0; m_cnt[o] = 0; end
        end else begin
            m_ov = 0;
            m_fin = 0;
            if (m_phase == 0) begin
                if (start) begin
                    m_phase = 1; m_steps = 0; m_thr = $signed(threshold);
                    for (int o = 0; o < NO; o++) begin m_v[o] = 0; m_cnt[o] = 0; end
                end
            end else if (m_phase == 1) begin
                if (in_valid) begin
                    for (int o = 0; o < NO; o++) begin
                        int syn, vn;
                        syn = 0;
                        for (int i = 0; i < NI; i++)
                            if (spike_in[i]) syn += weights[o*NI+i] ? 1 : -1;
                        vn = m_v[o] - (m_v[o] >>> 2) + syn;
                        if (vn > 127) vn = 127;
                        if (vn < -128) vn = -128;
                        m_spk[o] = (vn >= m_thr);
                        if (vn >= m_thr) begin m_v[o] = 0; m_cnt[o]++; end
                        else m_v[o] = vn;
                    end
                    m_ov = 1;
                    m_steps++;
                    if (m_steps == TS) begin m_phase = 2; m_fin = 1; end
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            logic [NO*5-1:0] ec;
            logic [NO*3-1:0] ec3;
            for (int o = 0; o < NO; o++) begin
                ec[o*5 +: 5]  = 5'((m_cnt[o] > 31) ? 31 : m_cnt[o]);
                ec3[o*3 +: 3] = 3'((m_cnt[o] > 7) ? 7 : m_cnt[o]);
            end
            chk("busy", busy, m_phase == 1);
            chk("in_ready", in_ready, m_phase == 1);
            chk("out_valid", out_valid, m_ov);
            chk("finish", finish, m_fin);
            chk("spike_out", spike_out, m_spk);
            chk("spike_count", spike_count, ec);
            chk("spike_count_w3", spike_count3, ec3);
            chk("finish_w3", finish3, m_fin);
        end
    end

    // One inference; rst_step >= 0 pulses nRST once that many steps are accepted.
    task automatic run_inf(input logic [7:0] thr, input logic [15:0] w, input logic [3:0] spk,
                           input bit rnd, input int gap, input int rst_step);
        int guard;
        @(negedge CLK);
        threshold = thr; weights = w; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        guard = 0;
        while (m_phase != 0 && guard < 400) begin
            if (rnd) begin
                spike_in = 4'($urandom);
                if ($urandom_range(0, 3) == 0) weights = 16'($urandom);
                in_valid = 1'($urandom_range(0, 1));
                start = ($urandom_range(0, 7) == 0);
            end else begin
                spike_in = spk;
                in_valid = (gap == 0) || (guard % (gap + 1) == gap);
                start = (guard == 5);
            end
            if (rst_step >= 0 && m_steps == rst_step) begin
                #2 nRST = 1'b0;
                #2 nRST = 1'b1;
            end
            @(negedge CLK);
            guard++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (guard >= 400) begin
            checks++; errors++;
            $display("FAIL timeout: inference did not end, steps %0d expected %0d", m_steps, TS);
        end
    endtask

    task automatic lit_counts(input string name, input int exp5, input int exp3);
        for (int o = 0; o < NO; o++) begin
            chk({name, "_model"}, m_cnt[o], exp5);
            chk({name, "_dut"}, spike_count[o*5 +: 5], exp5);
            chk({name, "_dut_w3"}, spike_count3[o*3 +: 3], exp3);
        end
    endtask

    initial begin
        #2 nRST = 1'b0;
        chk_en = 1;
        repeat (3) @(negedge CLK);
        chk("reset_busy", busy, 0);
        chk("reset_count", spike_count, 0);
        nRST = 1'b1;

        run_inf(8'd4, 16'hFFFF, 4'b1111, 0, 0, -1);
        lit_counts("fire_every_step", 16, 7);

        run_inf(8'd4, 16'h0000, 4'b1111, 0, 0, -1);
        lit_counts("all_negative", 0, 0);

        run_inf(8'd6, 16'hFFFF, 4'b0011, 0, 0, -1);
        lit_counts("thr6", 4, 4);

        run_inf(8'd5, 16'hFFFF, 4'b0011, 0, 0, -1);
        lit_counts("thr5", 5, 5);

        run_inf(8'd4, 16'hFFFF, 4'b1111, 0, 0, 7);
        lit_counts("after_reset", 0, 0);
        chk("after_reset_spk", spike_out, 0);
        run_inf(8'd4, 16'hFFFF, 4'b1111, 0, 0, -1);
        lit_counts("rerun", 16, 7);

        run_inf(8'd4, 16'hFFFF, 4'b1111, 0, 3, -1);
        lit_counts("gaps", 16, 7);

        for (int k = 0; k < 12; k++)
            run_inf(8'($urandom_range(0, 10) - 2), 16'($urandom), 4'b0, 1, 0, -1);

        repeat (3) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
